// File: rtl/ej32_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ej32_pkg
//  Description : Shared eJ32 types, opcode constants and the operand-length
//                table used by the bytecode fetcher and the core decoder.
//  Revision    : 1.0 - initial release
// ============================================================================
package ej32_pkg;

    typedef logic [7:0] opcode_t;

    typedef enum logic [1:0] {
        sREQ = 2'd0,
        sOP  = 2'd1,
        sOPD = 2'd2,
        sOUT = 2'd3
    } fetch_st;

    localparam opcode_t OP_NOP            = 8'h00;
    localparam opcode_t OP_BIPUSH         = 8'h10;
    localparam opcode_t OP_SIPUSH         = 8'h11;
    localparam opcode_t OP_TABLESWITCH    = 8'haa;
    localparam opcode_t OP_LOOKUPSWITCH   = 8'hab;
    localparam opcode_t OP_JNEW           = 8'hbb;
    localparam opcode_t OP_WIDE           = 8'hc4;
    localparam opcode_t OP_MULTIANEWARRAY = 8'hc5;
    localparam opcode_t OP_IFNULL         = 8'hc6;
    localparam opcode_t OP_IFNONNULL      = 8'hc7;
    localparam opcode_t OP_DONEXT         = 8'hca;
    localparam opcode_t OP_LDI            = 8'hcb;
    localparam opcode_t OP_EXT            = 8'hcf;
    localparam opcode_t OP_GET            = 8'hd0;
    localparam opcode_t OP_PUT            = 8'hd1;
    localparam opcode_t OP_FIRST_BAD      = 8'hd2;

    // Opcodes the fetcher cannot size: variable-length switches, wide, and
    // everything above the last eJ32 extension opcode.
    function automatic logic opd_err(input opcode_t op);
        return (op inside {OP_TABLESWITCH, OP_LOOKUPSWITCH, OP_WIDE}) ||
               (op >= OP_FIRST_BAD);
    endfunction

    // Number of operand bytes following the opcode byte.
    function automatic logic [2:0] opd_len(input opcode_t op);
        logic [2:0] len;
        len = 3'd0;
        if (op inside {OP_BIPUSH, 8'h12, [8'h15:8'h19], [8'h36:8'h3a], 8'ha9,
                       8'hbc, OP_EXT, OP_GET, OP_PUT}) begin
            len = 3'd1;
        end else if (op inside {OP_SIPUSH, 8'h13, 8'h14, 8'h84, [8'h99:8'ha8],
                                [8'hb2:8'hb8], OP_JNEW, 8'hbd, 8'hc0, 8'hc1,
                                OP_IFNULL, OP_IFNONNULL, OP_DONEXT}) begin
            len = 3'd2;
        end else if (op == OP_MULTIANEWARRAY) begin
            len = 3'd3;
        end else if (op inside {8'hb9, 8'hba, 8'hc8, 8'hc9, OP_LDI}) begin
            len = 3'd4;
        end
        return len;
    endfunction

    // Opcodes whose 16-bit operand is a signed value or branch offset.
    function automatic logic opd_sext16(input opcode_t op);
        return op inside {OP_SIPUSH, [8'h99:8'ha8], OP_IFNULL, OP_IFNONNULL, OP_DONEXT};
    endfunction

endpackage
`default_nettype wire

// File: rtl/ej32_oplen.sv
`default_nettype none
// ============================================================================
//  Module      : ej32_oplen
//  Description : Combinational opcode classifier: operand length, extension
//                class and unsupported-opcode flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module ej32_oplen
    import ej32_pkg::*;
(
    input  logic [7:0] i_op,
    output logic [2:0] o_len,
    output logic       o_sext8,
    output logic       o_sext16,
    output logic       o_err
);

    // Unsupported opcodes carry no operand and no extension.
    always_comb begin
        o_err    = opd_err(i_op);
        o_len    = o_err ? 3'd0 : opd_len(i_op);
        o_sext8  = !o_err && (i_op == OP_BIPUSH);
        o_sext16 = !o_err && opd_sext16(i_op);
    end

endmodule
`default_nettype wire

// File: rtl/ej32_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : ej32_fetch
//  Description : Bytecode fetcher. Reads opcode and big-endian operand bytes
//                from program memory and presents one packed instruction to
//                the core; the core may redirect it at any time.
//  Revision    : 1.0 - initial release
// ============================================================================
module ej32_fetch
    import ej32_pkg::*;
#(
    parameter logic [16:0] RST_PC = 17'h0
) (
    input  logic        clk,
    input  logic        rst,
    output logic [16:0] mem_a,
    output logic        mem_rd,
    input  logic [7:0]  mem_d,
    input  logic        jmp_en,
    input  logic [16:0] jmp_a,
    input  logic        op_rdy,
    output logic        op_v,
    output logic [7:0]  op,
    output logic [31:0] opd,
    output logic [16:0] op_pc,
    output logic        op_err
);

    fetch_st     state_q, state_d;
    logic [16:0] pc_q, pc_d;
    logic [2:0]  cnt_q, cnt_d;
    opcode_t     op_q, op_d;
    logic [31:0] opd_q, opd_d;
    logic [16:0] op_pc_q, op_pc_d;
    logic        op_err_q, op_err_d;

    opcode_t     ol_op;
    logic [2:0]  ol_len;
    logic        ol_sext8, ol_sext16, ol_err;
    logic [31:0] opd_shift, opd_final;

    // The classifier sees the fresh opcode byte in sOP, the latched one after.
    assign ol_op = (state_q == sOP) ? mem_d : op_q;

    ej32_oplen u_oplen (
        .i_op     (ol_op),
        .o_len    (ol_len),
        .o_sext8  (ol_sext8),
        .o_sext16 (ol_sext16),
        .o_err    (ol_err)
    );

    // Shift in the arriving operand byte and extend it if it is the last one.
    always_comb begin
        opd_shift = {opd_q[23:0], mem_d};
        opd_final = opd_shift;
        if (ol_sext8) begin
            opd_final = {{24{opd_shift[7]}}, opd_shift[7:0]};
        end else if (ol_sext16) begin
            opd_final = {{16{opd_shift[15]}}, opd_shift[15:0]};
        end
    end

    // Fetch sequencing; a redirect overrides whatever the FSM was doing.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        opd_d    = opd_q;
        op_pc_d  = op_pc_q;
        op_err_d = op_err_q;
        mem_rd   = 1'b0;
        if (rst) begin
            mem_rd = 1'b0;
        end else if (jmp_en) begin
            pc_d    = jmp_a;
            cnt_d   = 3'd0;
            state_d = sREQ;
        end else begin
            case (state_q)
                sREQ: begin
                    mem_rd  = 1'b1;
                    pc_d    = pc_q + 17'd1;
                    state_d = sOP;
                end
                sOP: begin
                    op_d     = mem_d;
                    op_pc_d  = pc_q - 17'd1;
                    opd_d    = 32'd0;
                    op_err_d = ol_err;
                    cnt_d    = ol_len;
                    if (ol_len == 3'd0) begin
                        state_d = sOUT;
                    end else begin
                        mem_rd  = 1'b1;
                        pc_d    = pc_q + 17'd1;
                        state_d = sOPD;
                    end
                end
                sOPD: begin
                    cnt_d = cnt_q - 3'd1;
                    if (cnt_q > 3'd1) begin
                        opd_d  = opd_shift;
                        mem_rd = 1'b1;
                        pc_d   = pc_q + 17'd1;
                    end else begin
                        opd_d   = opd_final;
                        state_d = sOUT;
                    end
                end
                sOUT: begin
                    if (op_rdy) begin
                        state_d = sREQ;
                    end
                end
                default: state_d = sREQ;
            endcase
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= sREQ;
            pc_q     <= RST_PC;
            cnt_q    <= 3'd0;
            op_q     <= OP_NOP;
            opd_q    <= 32'd0;
            op_pc_q  <= 17'd0;
            op_err_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            opd_q    <= opd_d;
            op_pc_q  <= op_pc_d;
            op_err_q <= op_err_d;
        end
    end

    assign mem_a  = pc_q;
    assign op_v   = (state_q == sOUT);
    assign op     = op_q;
    assign opd    = opd_q;
    assign op_pc  = op_pc_q;
    assign op_err = op_err_q;

endmodule
`default_nettype wire
